zeroriscy_fetch_fifo: RTL and testbench

Instruction prefetcher directly upstream of the IF stage. It issues sequential 32-bit word fetches on the instruction memory bus and buffers returned words with their addresses in a small FIFO. Buffered words are presented to the IF stage through a valid/ready handshake. A branch request flushes the FIFO, discards any in-flight response and restarts fetching at the new target.

---
 rtl/zeroriscy_fetch_fifo.sv | 175 +++++++++++++++++
 tb/tb_zeroriscy_fetch_fifo.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroriscy_fetch_fifo.sv
// zeroriscy_fetch_fifo: sequential instruction prefetcher feeding the IF stage.
// Issues one word fetch at a time on the instruction bus and buffers the
// returned words, with their addresses, in a DEPTH-entry FIFO. A branch
// flushes the FIFO, drops any in-flight response and restarts at the target.
// Optional macro ZRSCY_FETCH_BYPASS_EN: when the FIFO is empty, an accepted
// response is presented to the IF stage in the same cycle it arrives.
module zeroriscy_fetch_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        busy_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, ABORTED} state_t;

    state_t           r_state, w_state_next;
    logic             r_outstanding, w_outstanding_next;
    logic [31:0]      r_fetch_addr;
    logic [31:0]      r_gnt_addr;
    logic [CNT_W-1:0] r_count, w_count_next;
    logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
    logic [31:0]      r_addr_mem [DEPTH];
    logic [31:0]      r_data_mem [DEPTH];
    logic [31:0]      r_last_addr, r_last_data;

    logic             w_gnt, w_rvalid_acc, w_fifo_empty, w_bypass;
    logic             w_push, w_pop, w_space;
    logic [31:0]      w_head_addr, w_head_data;
    logic             w_unused;

    // Low address bits are irrelevant for word-aligned fetches.
    assign w_unused = &{1'b0, addr_i[1:0]};

    assign instr_req_o  = (r_state == WAIT_GNT);
    assign instr_addr_o = r_fetch_addr;
    assign busy_o       = (r_state != IDLE) || r_outstanding;

    assign w_gnt        = instr_req_o && instr_gnt_i;
    // Only a response to a live (non-aborted) transaction is stored.
    assign w_rvalid_acc = instr_rvalid_i && (r_state == WAIT_RVALID);
    assign w_fifo_empty = (r_count == '0);

`ifdef ZRSCY_FETCH_BYPASS_EN
    assign w_bypass = w_rvalid_acc && w_fifo_empty && !branch_i;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word consumed in the same cycle never enters the FIFO.
    assign w_push = w_rvalid_acc && !branch_i && !(w_bypass && ready_i);
    assign w_pop  = !w_fifo_empty && ready_i && !branch_i;

    assign w_head_addr = w_bypass ? r_gnt_addr :
                         (w_fifo_empty ? r_last_addr : r_addr_mem[r_rd_ptr]);
    assign w_head_data = w_bypass ? instr_rdata_i :
                         (w_fifo_empty ? r_last_data : r_data_mem[r_rd_ptr]);

    assign valid_o = (!w_fifo_empty || w_bypass) && !branch_i;
    assign rdata_o = w_head_data;
    assign addr_o  = w_head_addr;

    // Occupancy after this cycle's push/pop; a branch empties the FIFO.
    always_comb begin
        w_count_next = r_count;
        if (branch_i) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // A new request is only allowed if its response is guaranteed a slot.
    assign w_space = req_i && (w_count_next < DEPTH_C);

    // Next state and outstanding flag; branch overrides everything else.
    always_comb begin
        w_state_next       = r_state;
        w_outstanding_next = r_outstanding;
        case (r_state)
            IDLE: begin
                if (w_space) w_state_next = WAIT_GNT;
            end
            WAIT_GNT: begin
                if (w_gnt) begin
                    w_state_next       = WAIT_RVALID;
                    w_outstanding_next = 1'b1;
                end
            end
            WAIT_RVALID, ABORTED: begin
                if (instr_rvalid_i) begin
                    w_outstanding_next = 1'b0;
                    w_state_next       = w_space ? WAIT_GNT : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (branch_i) begin
            if (w_gnt) begin
                w_state_next       = ABORTED;
                w_outstanding_next = 1'b1;
            end else if (r_outstanding && !instr_rvalid_i) begin
                w_state_next       = ABORTED;
            end else begin
                w_outstanding_next = 1'b0;
                w_state_next       = req_i ? WAIT_GNT : IDLE;
            end
        end
    end

    // Control registers: state, fetch address, pointers, last head word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_outstanding <= 1'b0;
            r_fetch_addr  <= '0;
            r_gnt_addr    <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_last_addr   <= '0;
            r_last_data   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_outstanding_next;
            r_count       <= w_count_next;
            if (w_gnt) r_gnt_addr <= r_fetch_addr;
            if (branch_i) begin
                r_fetch_addr <= {addr_i[31:2], 2'b00};
                r_rd_ptr     <= '0;
                r_wr_ptr     <= '0;
            end else begin
                if (w_gnt)  r_fetch_addr <= r_fetch_addr + 32'd4;
                if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            if (valid_o) begin
                r_last_addr <= w_head_addr;
                r_last_data <= w_head_data;
            end
        end
    end

    // FIFO storage: entries cleared on reset, written at the write pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr_mem[i] <= '0;
                r_data_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_addr_mem[r_wr_ptr] <= r_gnt_addr;
            r_data_mem[r_wr_ptr] <= instr_rdata_i;
        end
    end

endmodule

// File: tb/tb_zeroriscy_fetch_fifo.sv
// Testbench for zeroriscy_fetch_fifo (default build, bypass disabled).
// A bus responder answers grants after 1..3 cycles with address-derived data;
// a transaction-level queue model predicts what the IF stage must see.
module tb_zeroriscy_fetch_fifo;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        ready_i = 1'b0;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        valid_o, instr_req_o, busy_o;
    logic [31:0] rdata_o, addr_o, instr_addr_o;

    int n_cmp = 0;
    int n_fail = 0;

    zeroriscy_fetch_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i),
        .addr_i(addr_i), .ready_i(ready_i), .valid_o(valid_o),
        .rdata_o(rdata_o), .addr_o(addr_o), .instr_req_o(instr_req_o),
        .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC001D00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver / bus responder ----------------
    int          rv_wait = 0;
    int          rv_delay_fixed = 1;
    int          gnt_mode = 1;
    logic [31:0] rv_addr = '0;
    logic [31:0] grant_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] pop_data[$];
    int          cyc = 0;
    int          first_rv_cyc = -1;
    int          first_valid_cyc = -1;
    int          total_pops = 0;

    task automatic tick();
        logic        g;
        logic [31:0] ga;
        #1;
        g  = instr_req_o && instr_gnt_i;
        ga = instr_addr_o;
        if (g) grant_log.push_back(ga);
        if (valid_o && ready_i && !branch_i) begin
            pop_log.push_back(addr_o);
            pop_data.push_back(rdata_o);
            total_pops++;
        end
        if (instr_rvalid_i && first_rv_cyc < 0) first_rv_cyc = cyc;
        if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        @(posedge clk);
        #1;
        cyc++;
        if (g) begin
            rv_wait = (rv_delay_fixed > 0) ? rv_delay_fixed : int'($urandom_range(1, 3));
            rv_addr = ga;
        end
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = $urandom;
        if (rv_wait > 0) begin
            rv_wait--;
            if (rv_wait == 0) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = memf(rv_addr);
            end
        end
        case (gnt_mode)
            0:       instr_gnt_i = 1'b0;
            1:       instr_gnt_i = 1'b1;
            default: instr_gnt_i = ($urandom_range(0, 9) < 7);
        endcase
    endtask

    task automatic clear_logs();
        grant_log.delete();
        pop_log.delete();
        pop_data.delete();
        first_rv_cyc = -1;
        first_valid_cyc = -1;
    endtask

    task automatic do_branch(input logic [31:0] target);
        branch_i = 1'b1;
        addr_i   = target;
        tick();
        branch_i = 1'b0;
        clear_logs();
    endtask

    // ---------------- reference model + compare process ----------------
    logic [31:0] mq_addr[$];
    logic [31:0] mq_data[$];
    logic        m_out = 1'b0;
    logic        m_drop = 1'b0;
    logic [31:0] m_out_addr = '0;
    logic [31:0] m_fetch = '0;
    logic        prev_rst_low = 1'b1;
    int          starve = 0;

    // Every cycle: compare DUT outputs with the model, then advance the model.
    always @(negedge clk) begin : compare_proc
        logic exp_valid, grant_now, rv_now;
        if (prev_rst_low) begin
            chk("rst_valid", valid_o, 1'b0);
            chk("rst_rdata", rdata_o, 32'h0);
            chk("rst_addr", addr_o, 32'h0);
            chk("rst_req", instr_req_o, 1'b0);
            chk("rst_busy", busy_o, 1'b0);
        end
        exp_valid = (mq_addr.size() > 0) && !branch_i;
        chk("valid_o", valid_o, exp_valid);
        if (exp_valid && valid_o) begin
            chk("head_addr", addr_o, mq_addr[0]);
            chk("head_data", rdata_o, mq_data[0]);
        end
        if (instr_req_o) begin
            chk("req_addr", instr_addr_o, m_fetch);
            chk("req_space", (!m_out && mq_addr.size() < DEPTH), 1'b1);
        end
        chk("busy_o", busy_o, instr_req_o || m_out);
        if (rst_n && req_i && !m_out && !instr_req_o && mq_addr.size() < DEPTH)
            starve++;
        else
            starve = 0;
        if (starve >= 2) begin
            chk("req_starve", starve, 1);
            starve = 0;
        end

        grant_now = instr_req_o && instr_gnt_i;
        rv_now    = instr_rvalid_i && m_out;
        if (!rst_n) begin
            mq_addr.delete();
            mq_data.delete();
            m_out   = 1'b0;
            m_drop  = 1'b0;
            m_fetch = '0;
        end else if (branch_i) begin
            mq_addr.delete();
            mq_data.delete();
            m_fetch = {addr_i[31:2], 2'b00};
            if (grant_now) begin
                m_out  = 1'b1;
                m_drop = 1'b1;
            end else if (rv_now) begin
                m_out = 1'b0;
            end else if (m_out) begin
                m_drop = 1'b1;
            end
        end else begin
            if (exp_valid && ready_i) begin
                void'(mq_addr.pop_front());
                void'(mq_data.pop_front());
            end
            if (rv_now) begin
                if (!m_drop) begin
                    mq_addr.push_back(m_out_addr);
                    mq_data.push_back(instr_rdata_i);
                end
                m_out  = 1'b0;
                m_drop = 1'b0;
            end
            if (grant_now) begin
                m_out      = 1'b1;
                m_drop     = 1'b0;
                m_out_addr = m_fetch;
                m_fetch    = m_fetch + 32'd4;
            end
        end
        prev_rst_low = !rst_n;
    end

    // ---------------- directed tests, then random traffic ----------------
    initial begin
        logic [31:0] a0;
        logic        ok;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk("init_valid", valid_o, 1'b0);
        chk("init_req", instr_req_o, 1'b0);
        chk("init_busy", busy_o, 1'b0);

        // T1: streaming fetch from 0x80 with immediate grants.
        req_i = 1'b1; ready_i = 1'b1; gnt_mode = 1; instr_gnt_i = 1'b1; rv_delay_fixed = 1;
        do_branch(32'h80);
        for (int i = 0; i < 30 && !(grant_log.size() >= 3 && pop_log.size() >= 3); i++) tick();
        ok = (grant_log.size() >= 3 && pop_log.size() >= 3);
        chk("t1_progress", ok, 1'b1);
        if (ok) begin
            chk("t1_gnt0", grant_log[0], 32'h80);
            chk("t1_gnt1", grant_log[1], 32'h84);
            chk("t1_gnt2", grant_log[2], 32'h88);
            chk("t1_pop0", pop_log[0], 32'h80);
            chk("t1_pop1", pop_log[1], 32'h84);
            chk("t1_pop2", pop_log[2], 32'h88);
            chk("t1_dat0", pop_data[0], memf(32'h80));
            chk("t1_dat2", pop_data[2], memf(32'h88));
        end
        chk("t1_valid_latency", 32'(first_valid_cyc - first_rv_cyc), 32'd1);
        $display("T1 stream from 0x80: %0d grants, %0d pops", grant_log.size(), pop_log.size());

        // T2: consumer stalled, FIFO fills after exactly DEPTH grants.
        ready_i = 1'b0;
        do_branch(32'h80);
        repeat (12) tick();
        #1;
        chk("t2_grants", grant_log.size(), DEPTH);
        chk("t2_req", instr_req_o, 1'b0);
        chk("t2_valid", valid_o, 1'b1);
        chk("t2_busy", busy_o, 1'b0);
        chk("t2_head", addr_o, 32'h80);
        ready_i = 1'b1;
        for (int i = 0; i < 10 && grant_log.size() < 3; i++) tick();
        chk("t2_resume_progress", grant_log.size() >= 3, 1'b1);
        if (grant_log.size() >= 3) chk("t2_resume_addr", grant_log[2], 32'h88);
        $display("T2 full FIFO: resumed after %0d grants", grant_log.size());

        // T3: branch while the response to 0x84 is in flight.
        rv_delay_fixed = 2;
        do_branch(32'h80);
        for (int i = 0; i < 40 && !(grant_log.size() > 0 && grant_log[$] == 32'h84); i++) tick();
        chk("t3_saw_0x84", (grant_log.size() > 0 && grant_log[$] == 32'h84), 1'b1);
        do_branch(32'h200);
        #1;
        chk("t3_empty_after_branch", valid_o, 1'b0);
        for (int i = 0; i < 20 && pop_log.size() < 1; i++) tick();
        chk("t3_pop_progress", pop_log.size() >= 1, 1'b1);
        if (pop_log.size() >= 1) begin
            chk("t3_first_addr", pop_log[0], 32'h200);
            chk("t3_first_data", pop_data[0], memf(32'h200));
        end
        $display("T3 branch to 0x200 with in-flight response");

        // T4: no grants; request address stable, then redirected by a branch.
        gnt_mode = 0; instr_gnt_i = 1'b0;
        do_branch(32'h100);
        for (int i = 0; i < 10; i++) begin
            #1;
            if (instr_req_o) break;
            tick();
        end
        a0 = instr_addr_o;
        chk("t4_req_addr", a0, 32'h100);
        tick();
        #1;
        chk("t4_req_held", instr_req_o, 1'b1);
        chk("t4_addr_held", instr_addr_o, a0);
        branch_i = 1'b1; addr_i = 32'h43;
        tick();
        branch_i = 1'b0;
        #1;
        chk("t4_req_after_branch", instr_req_o, 1'b1);
        chk("t4_addr_after_branch", instr_addr_o, 32'h40);
        $display("T4 stalled grant, redirected to 0x40");

        // T5: fetch address wraps past the top of the address space.
        gnt_mode = 1; instr_gnt_i = 1'b1; rv_delay_fixed = 1;
        do_branch(32'hFFFF_FFFC);
        for (int i = 0; i < 30 && !(grant_log.size() >= 2 && pop_log.size() >= 2); i++) tick();
        ok = (grant_log.size() >= 2 && pop_log.size() >= 2);
        chk("t5_progress", ok, 1'b1);
        if (ok) begin
            chk("t5_gnt0", grant_log[0], 32'hFFFF_FFFC);
            chk("t5_gnt1", grant_log[1], 32'h0000_0000);
            chk("t5_pop1", pop_log[1], 32'h0000_0000);
        end
        $display("T5 address wrap 0xFFFFFFFC -> 0x00000000");

        // T6: reset while waiting for a response that arrives right after.
        rv_delay_fixed = 2;
        grant_log.delete();
        for (int i = 0; i < 20 && grant_log.size() < 1; i++) tick();
        chk("t6_grant_seen", grant_log.size() >= 1, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6_valid", valid_o, 1'b0);
        chk("t6_rdata", rdata_o, 32'h0);
        chk("t6_addr", addr_o, 32'h0);
        chk("t6_req", instr_req_o, 1'b0);
        chk("t6_busy", busy_o, 1'b0);
        tick();
        #1;
        chk("t6_no_push", valid_o, 1'b0);
        chk("t6_restart_req", instr_req_o, 1'b1);
        chk("t6_restart_addr", instr_addr_o, 32'h0);
        $display("T6 reset during WAIT_RVALID");

        // Random traffic checked cycle by cycle against the model.
        rv_delay_fixed = 0; gnt_mode = 2;
        total_pops = 0;
        for (int n = 0; n < 3000; n++) begin
            req_i    = ($urandom_range(0, 9) != 0);
            ready_i  = ($urandom_range(0, 9) < 6);
            branch_i = ($urandom_range(0, 24) == 0);
            addr_i   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            tick();
        end
        branch_i = 1'b0;
        chk("random_pops_seen", total_pops > 100, 1'b1);
        $display("Random phase: %0d words consumed", total_pops);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
